// File: rtl/alu_out_collector_pkg.sv
// Shared widths and the tagged FIFO entry type for the multi-channel ALU result collector.
package alu_out_collector_pkg;

    localparam int unsigned NUM_CH       = 4;
    localparam int unsigned RESULT_WIDTH = 16;
    localparam int unsigned DEPTH        = 8;

    // Channel tag width; at least one bit even for a single channel
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CH_W  = ch_width(NUM_CH);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [CH_W-1:0]         ch;
        logic [RESULT_WIDTH-1:0] result;
    } entry_t;

endpackage

// File: rtl/alu_out_collector_if.sv
// Result-capture and result-stream bundle between the ALU channels, the collector and its consumer.
interface alu_out_collector_if;
    import alu_out_collector_pkg::*;

    logic [NUM_CH-1:0]              in_done;
    logic [NUM_CH*RESULT_WIDTH-1:0] in_result;
    logic                           out_valid;
    logic                           out_ready;
    logic [RESULT_WIDTH-1:0]        out_result;
    logic [CH_W-1:0]                out_ch;
    logic [CNT_W-1:0]               out_count;
    logic [NUM_CH-1:0]              overflow;
    logic                           clr_overflow;

    modport master (
        output in_done, in_result, out_ready, clr_overflow,
        input  out_valid, out_result, out_ch, out_count, overflow
    );

    modport slave (
        input  in_done, in_result, out_ready, clr_overflow,
        output out_valid, out_result, out_ch, out_count, overflow
    );

endinterface

// File: rtl/alu_out_tag_fifo.sv
// Show-ahead FIFO of channel-tagged results; the head keeps showing the last popped entry when empty.
module alu_out_tag_fifo
    import alu_out_collector_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  entry_t           i_data,
    input  logic             i_pop,
    output entry_t           o_head,
    output logic [CNT_W-1:0] o_count
);

    entry_t           r_mem [DEPTH];
    logic [CNT_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_rd_ptr;
    logic             w_empty;
    logic             w_do_pop;
    logic [PTR_W-1:0] w_last_idx;

    assign o_count    = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (o_count == '0);
    assign w_do_pop   = i_pop && !w_empty;
    assign w_last_idx = r_rd_ptr[PTR_W-1:0] - PTR_W'(1);

    // When empty, wr==rd so the slot behind rd still holds the last popped entry
    assign o_head = w_empty ? r_mem[w_last_idx] : r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
                r_wr_ptr                   <= r_wr_ptr + CNT_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_out_collector.sv
// Captures per-channel ALU results into hold registers and merges them round-robin into a tagged FIFO.
module alu_out_collector
    import alu_out_collector_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    alu_out_collector_if.slave bus
);

    logic [NUM_CH-1:0]       r_hold_vld;
    logic [RESULT_WIDTH-1:0] r_hold [NUM_CH];
    logic [CH_W-1:0]         r_rr;
    logic [NUM_CH-1:0]       r_ovf;

    logic                    w_pop;
    logic                    w_push_ok;
    logic                    w_grant_vld;
    logic [CH_W-1:0]         w_grant_idx;
    logic [CH_W-1:0]         w_scan_idx;
    logic [NUM_CH-1:0]       w_grant;
    logic [NUM_CH-1:0]       w_capture;
    logic [NUM_CH-1:0]       w_ovf_set;
    entry_t                  w_push_data;
    entry_t                  w_head;
    logic [CNT_W-1:0]        w_count;

    assign w_pop     = (w_count != '0) && bus.out_ready;
    assign w_push_ok = (w_count < CNT_W'(DEPTH)) || w_pop;

    // First full hold register at or after the round-robin pointer wins
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        w_grant     = '0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            w_scan_idx = CH_W'((32'(r_rr) + off) % NUM_CH);
            if (!w_grant_vld && w_push_ok && r_hold_vld[w_scan_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
        if (w_grant_vld) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    // A hold register freed by this cycle's grant may take a new result at once
    assign w_capture = bus.in_done & (~r_hold_vld | w_grant);
    assign w_ovf_set = bus.in_done & r_hold_vld & ~w_grant;

    assign w_push_data.ch     = w_grant_idx;
    assign w_push_data.result = r_hold[w_grant_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold_vld <= '0;
            r_hold     <= '{default: '0};
            r_rr       <= '0;
            r_ovf      <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (w_capture[i]) begin
                    r_hold[i]     <= bus.in_result[i*RESULT_WIDTH +: RESULT_WIDTH];
                    r_hold_vld[i] <= 1'b1;
                end else if (w_grant[i]) begin
                    r_hold_vld[i] <= 1'b0;
                end
            end
            // New loss beats a simultaneous clear
            r_ovf <= (bus.clr_overflow ? '0 : r_ovf) | w_ovf_set;
            if (w_grant_vld) begin
                r_rr <= (32'(w_grant_idx) == NUM_CH - 1) ? '0 : w_grant_idx + CH_W'(1);
            end
        end
    end

    alu_out_tag_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_grant_vld),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign bus.out_valid  = (w_count != '0);
    assign bus.out_result = w_head.result;
    assign bus.out_ch     = w_head.ch;
    assign bus.out_count  = w_count;
    assign bus.overflow   = r_ovf;

endmodule
